// File: rtl/mem_bus_arbiter.sv
// Arbitrates one external req/ack memory bus between the IF fetch port and the MEM load/store
// port. Completed read data is held until the owning pipeline stage advances.
module mem_bus_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter bit          MEM_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              if_stall_i,
  input  logic              mem_stall_i,
  input  logic              if_ce_i,
  input  logic [DATA_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              stallreq_if_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              stallreq_mem_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_ack_i
);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyMem, StDrain} state_e;

  state_e state_q;
  logic   if_done_q;
  logic   mem_done_q;
  logic   last_mem_q;
  logic   if_pend;
  logic   mem_pend;
  logic   grant_mem;

  // Requests are masked while reset is asserted so stall requests stay low.
  assign if_pend  = rst & if_ce_i & ~if_done_q;
  assign mem_pend = rst & mem_ce_i & ~mem_done_q;

  assign stallreq_if_o  = if_pend;
  assign stallreq_mem_o = mem_pend;

  // Only meaningful when at least one requester is pending.
  assign grant_mem = MEM_PRIO ? mem_pend : (mem_pend & (~if_pend | ~last_mem_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      last_mem_q <= 1'b0;
      if_data_o  <= '0;
      mem_data_o <= '0;
      bus_req_o  <= 1'b0;
      bus_we_o   <= 1'b0;
      bus_sel_o  <= 4'b0000;
      bus_addr_o <= '0;
      bus_data_o <= '0;
    end else begin
      // A done flag lives until its stage is released, blocking a re-issue of the same access.
      if (if_done_q && !if_stall_i) if_done_q <= 1'b0;
      if (mem_done_q && !mem_stall_i) mem_done_q <= 1'b0;
      if (flush_i) begin
        if_done_q  <= 1'b0;
        mem_done_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (!flush_i && (if_pend || mem_pend)) begin
            bus_req_o  <= 1'b1;
            last_mem_q <= grant_mem;
            if (grant_mem) begin
              state_q    <= StBusyMem;
              bus_we_o   <= mem_we_i;
              bus_sel_o  <= mem_sel_i;
              bus_addr_o <= mem_addr_i;
              bus_data_o <= mem_data_i;
            end else begin
              state_q    <= StBusyIf;
              bus_we_o   <= 1'b0;
              bus_sel_o  <= 4'b1111;
              bus_addr_o <= if_addr_i;
              bus_data_o <= '0;
            end
          end
        end
        StBusyIf, StBusyMem: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            state_q   <= StIdle;
            // A flush coinciding with the ack retires the cycle but discards its result.
            if (!flush_i) begin
              if (state_q == StBusyIf) begin
                if_data_o <= bus_data_i;
                if_done_q <= 1'b1;
              end else begin
                if (!bus_we_o) mem_data_o <= bus_data_i;
                mem_done_q <= 1'b1;
              end
            end
          end else if (flush_i) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a scoreboard checks every bus transaction the DUT opens,
// and the stimulus checks buffered data, stall requests and the round-robin variant.
module tb_mem_bus_arbiter;

  localparam int unsigned W = 32;

  typedef struct {
    logic         we;
    logic [3:0]   sel;
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } txn_t;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         if_stall;
  logic         mem_stall;
  logic         if_ce;
  logic [W-1:0] if_addr;
  logic [W-1:0] if_data;
  logic         stallreq_if;
  logic         mem_ce;
  logic         mem_we;
  logic [3:0]   mem_sel;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_data;
  logic         stallreq_mem;
  logic         bus_req;
  logic         bus_we;
  logic [3:0]   bus_sel;
  logic [W-1:0] bus_addr;
  logic [W-1:0] bus_wdata;
  logic [W-1:0] bus_rdata;
  logic         bus_ack;

  // Second instance (round-robin) with its own request, ack and bus signals.
  logic         p0_if_ce;
  logic         p0_mem_ce;
  logic         p0_ack;
  logic [W-1:0] p0_rdata;
  logic [W-1:0] p0_if_data;
  logic [W-1:0] p0_mem_data;
  logic         p0_stallreq_if;
  logic         p0_stallreq_mem;
  logic         p0_req;
  logic         p0_we;
  logic [3:0]   p0_sel;
  logic [W-1:0] p0_addr;
  logic [W-1:0] p0_wdata;

  logic         ack_hold;
  int           ack_dly;
  int           n_chk;
  int           n_fail;
  txn_t         exp_q[$];
  logic         req_prev;

  mem_bus_arbiter #(.DATA_W(W), .MEM_PRIO(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush),
    .if_stall_i     (if_stall),
    .mem_stall_i    (mem_stall),
    .if_ce_i        (if_ce),
    .if_addr_i      (if_addr),
    .if_data_o      (if_data),
    .stallreq_if_o  (stallreq_if),
    .mem_ce_i       (mem_ce),
    .mem_we_i       (mem_we),
    .mem_sel_i      (mem_sel),
    .mem_addr_i     (mem_addr),
    .mem_data_i     (mem_wdata),
    .mem_data_o     (mem_data),
    .stallreq_mem_o (stallreq_mem),
    .bus_req_o      (bus_req),
    .bus_we_o       (bus_we),
    .bus_sel_o      (bus_sel),
    .bus_addr_o     (bus_addr),
    .bus_data_o     (bus_wdata),
    .bus_data_i     (bus_rdata),
    .bus_ack_i      (bus_ack)
  );

  mem_bus_arbiter #(.DATA_W(W), .MEM_PRIO(1'b0)) dut_rr (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush),
    .if_stall_i     (if_stall),
    .mem_stall_i    (mem_stall),
    .if_ce_i        (p0_if_ce),
    .if_addr_i      (if_addr),
    .if_data_o      (p0_if_data),
    .stallreq_if_o  (p0_stallreq_if),
    .mem_ce_i       (p0_mem_ce),
    .mem_we_i       (mem_we),
    .mem_sel_i      (mem_sel),
    .mem_addr_i     (mem_addr),
    .mem_data_i     (mem_wdata),
    .mem_data_o     (p0_mem_data),
    .stallreq_mem_o (p0_stallreq_mem),
    .bus_req_o      (p0_req),
    .bus_we_o       (p0_we),
    .bus_sel_o      (p0_sel),
    .bus_addr_o     (p0_addr),
    .bus_data_o     (p0_wdata),
    .bus_data_i     (p0_rdata),
    .bus_ack_i      (p0_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rd_model(input logic [W-1:0] a);
    return 32'h5A00_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [3:0] sel, input logic [W-1:0] addr,
                      input logic [W-1:0] data);
    txn_t t;
    t.we = we; t.sel = sel; t.addr = addr; t.data = data;
    exp_q.push_back(t);
  endtask

  task automatic wait_clear(input bit is_mem, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((is_mem ? stallreq_mem : stallreq_if) && n < 50);
    chk(name, 32'(is_mem ? stallreq_mem : stallreq_if), 32'd0);
  endtask

  task automatic wait_req(input logic val, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_req !== val && n < 40);
    chk(name, 32'(bus_req), 32'(val));
  endtask

  // Bus slave: acks after ack_dly cycles of bus_req unless ack_hold is set.
  initial begin
    int cnt;
    cnt = 0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
      if (bus_req && !ack_hold) begin
        if (cnt >= ack_dly - 1) begin
          bus_ack = 1'b1;
          bus_rdata = rd_model(bus_addr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor: every new bus cycle must match the next expected transaction.
  initial req_prev = 1'b0;
  always @(negedge clk) begin
    if (bus_req && !req_prev) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected bus cycle: got addr %h, required no cycle", bus_addr);
      end else begin
        txn_t t;
        t = exp_q.pop_front();
        chk("bus_we", 32'(bus_we), 32'(t.we));
        chk("bus_sel", 32'(bus_sel), 32'(t.sel));
        chk("bus_addr", bus_addr, t.addr);
        chk("bus_data", bus_wdata, t.data);
      end
    end
    req_prev = bus_req;
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b0; flush = 1'b0; if_stall = 1'b0; mem_stall = 1'b0;
    if_ce = 1'b0; if_addr = '0; mem_ce = 1'b0; mem_we = 1'b0; mem_sel = 4'h0;
    mem_addr = '0; mem_wdata = '0;
    p0_if_ce = 1'b0; p0_mem_ce = 1'b0; p0_ack = 1'b0; p0_rdata = '0;
    ack_hold = 1'b0; ack_dly = 3;

    // Reset state, with a request raised during reset
    #3 if_ce = 1'b1;
    #1;
    chk("reset stallreq_if", 32'(stallreq_if), 32'd0);
    chk("reset bus_req", 32'(bus_req), 32'd0);
    chk("reset bus_sel", 32'(bus_sel), 32'd0);
    chk("reset bus_addr", bus_addr, 32'd0);
    chk("reset if_data", if_data, 32'd0);
    chk("reset mem_data", mem_data, 32'd0);
    if_ce = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // IF only, ack 3 cycles after bus_req, stage held after completion
    @(posedge clk); #1;
    if_addr = 32'h100; if_ce = 1'b1; if_stall = 1'b1;
    push(1'b0, 4'hF, 32'h100, 32'h0);
    #1 chk("if stallreq raised", 32'(stallreq_if), 32'd1);
    @(negedge clk) chk("if req not same cycle", 32'(bus_req), 32'd0);
    @(negedge clk) chk("if req latency", 32'(bus_req), 32'd1);
    wait_clear(1'b0, "if complete");
    chk("if data", if_data, rd_model(32'h100));
    repeat (4) @(negedge clk);
    chk("if held no reissue", 32'(stallreq_if), 32'd0);
    @(posedge clk); #1 if_stall = 1'b0; if_ce = 1'b0;

    // IF + MEM store in the same cycle: MEM first, IF after one idle cycle
    @(posedge clk); #1;
    if_addr = 32'h104; if_ce = 1'b1;
    mem_we = 1'b1; mem_sel = 4'hF; mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF; mem_ce = 1'b1;
    push(1'b1, 4'hF, 32'h200, 32'hDEAD_BEEF);
    push(1'b0, 4'hF, 32'h104, 32'h0);
    wait_clear(1'b1, "sw complete");
    chk("idle gap", 32'(bus_req), 32'd0);
    chk("sw leaves mem_data", mem_data, 32'd0);
    @(posedge clk); #1 mem_ce = 1'b0;
    @(negedge clk);
    chk("if after mem req", 32'(bus_req), 32'd1);
    chk("if after mem addr", bus_addr, 32'h104);
    wait_clear(1'b0, "if2 complete");
    chk("if2 data", if_data, rd_model(32'h104));
    @(posedge clk); #1 if_ce = 1'b0;

    // Back-to-back MEM loads, stage advancing each time
    @(negedge clk) ack_dly = 1;
    @(posedge clk); #1;
    mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h300; mem_wdata = '0; mem_ce = 1'b1;
    push(1'b0, 4'hF, 32'h300, 32'h0);
    wait_clear(1'b1, "lw1 complete");
    chk("lw1 data", mem_data, rd_model(32'h300));
    @(posedge clk); #1 mem_addr = 32'h304;
    push(1'b0, 4'hF, 32'h304, 32'h0);
    wait_clear(1'b1, "lw2 complete");
    chk("lw2 data", mem_data, rd_model(32'h304));
    @(posedge clk); #1 mem_ce = 1'b0;

    // Byte store
    @(posedge clk); #1;
    mem_we = 1'b1; mem_sel = 4'b0010; mem_addr = 32'h203; mem_wdata = 32'h0000_AB00; mem_ce = 1'b1;
    push(1'b1, 4'b0010, 32'h203, 32'h0000_AB00);
    wait_clear(1'b1, "sb complete");
    chk("sb leaves mem_data", mem_data, rd_model(32'h304));
    @(posedge clk); #1 mem_ce = 1'b0; mem_we = 1'b0;

    // Flush during BUSY_IF: drain, discard, re-arbitrate
    @(negedge clk) begin ack_hold = 1'b1; ack_dly = 2; end
    @(posedge clk); #1 if_addr = 32'h140; if_ce = 1'b1;
    push(1'b0, 4'hF, 32'h140, 32'h0);
    push(1'b0, 4'hF, 32'h140, 32'h0);
    wait_req(1'b1, "flush req up");
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("drain holds req", 32'(bus_req), 32'd1);
    chk("drain stallreq", 32'(stallreq_if), 32'd1);
    ack_hold = 1'b0;
    wait_req(1'b0, "drain ack");
    chk("drain discards data", if_data, rd_model(32'h104));
    wait_clear(1'b0, "reissue complete");
    chk("reissue data", if_data, rd_model(32'h140));
    @(posedge clk); #1 if_ce = 1'b0;

    // Reset while bus_req is high, then reissue
    @(negedge clk) ack_hold = 1'b1;
    @(posedge clk); #1 if_addr = 32'h180; if_ce = 1'b1;
    push(1'b0, 4'hF, 32'h180, 32'h0);
    push(1'b0, 4'hF, 32'h180, 32'h0);
    wait_req(1'b1, "pre-reset req");
    #2 rst = 1'b0;
    #1;
    chk("async reset req", 32'(bus_req), 32'd0);
    chk("async reset addr", bus_addr, 32'd0);
    chk("async reset stallreq", 32'(stallreq_if), 32'd0);
    chk("async reset if_data", if_data, 32'd0);
    @(negedge clk) ack_hold = 1'b0;
    #2 rst = 1'b1;
    wait_clear(1'b0, "post-reset complete");
    chk("post-reset data", if_data, rd_model(32'h180));
    @(posedge clk); #1 if_ce = 1'b0;

    // Round-robin instance: last grant MEM, so IF wins the next conflict
    @(posedge clk); #1;
    mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h400; p0_mem_ce = 1'b1;
    @(posedge clk); #1;
    chk("rr mem req", 32'(p0_req), 32'd1);
    chk("rr mem addr", p0_addr, 32'h400);
    p0_ack = 1'b1;
    @(posedge clk); #1 p0_ack = 1'b0; p0_mem_ce = 1'b0;
    chk("rr mem retired", 32'(p0_req), 32'd0);
    @(posedge clk); #1;
    if_addr = 32'h500; mem_addr = 32'h600; p0_if_ce = 1'b1; p0_mem_ce = 1'b1;
    @(posedge clk); #1;
    chk("rr if first addr", p0_addr, 32'h500);
    chk("rr if first we", 32'(p0_we), 32'd0);
    p0_rdata = 32'h1111_2222; p0_ack = 1'b1;
    @(posedge clk); #1 p0_ack = 1'b0; p0_if_ce = 1'b0;
    chk("rr if data", p0_if_data, 32'h1111_2222);
    @(posedge clk); #1;
    chk("rr mem second req", 32'(p0_req), 32'd1);
    chk("rr mem second addr", p0_addr, 32'h600);
    p0_ack = 1'b1;
    @(posedge clk); #1 p0_ack = 1'b0; p0_mem_ce = 1'b0;

    repeat (4) @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
